sram_req_adapter: RTL and testbench

- Valid/ready request front-end for the 2048x32 single-port SRAM wrapper (active-low CEB/WEB, 1-cycle read latency, clock gated by scan enable).
- Converts a streaming read/write request channel into macro pin activity.
- Captures read data Q in the cycle after issue into a small response FIFO so consumer back-pressure never loses data.
- Sits directly upstream of the SRAM wrapper inside the hwpe-mac-engine memory path.

---
 rtl/sram_adapter_pkg.sv | 13 +
 rtl/sram_rsp_fifo.sv | 38 +++
 rtl/sram_req_adapter.sv | 58 +++++
 tb/tb_sram_req_adapter.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/sram_adapter_pkg.sv
// sram_adapter_pkg: shared geometry and request/response types for the SRAM front-end
package sram_adapter_pkg;
  localparam int SRAM_NUM_WORD = 2048;
  localparam int SRAM_NUM_BIT = 32;
  typedef struct packed {
    logic we;
    logic [$clog2(SRAM_NUM_WORD)-1:0] addr;
    logic [SRAM_NUM_BIT-1:0] wdata;
  } sram_req_t;
  typedef struct packed {
    logic [SRAM_NUM_BIT-1:0] rdata;
  } sram_rsp_t;
endpackage

// File: rtl/sram_rsp_fifo.sv
// sram_rsp_fifo: small circular response FIFO with occupancy count
module sram_rsp_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 32,
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (push) wr_ptr <= nxt(wr_ptr);
      if (pop) rd_ptr <= nxt(rd_ptr);
      count <= count + CW'(push) - CW'(pop);
    end
  end
  always_ff @(posedge clk) if (push) mem[wr_ptr] <= wdata;
  assign rdata = mem[rd_ptr];
  assign full = count == CW'(DEPTH);
  assign empty = count == '0;
endmodule

// File: rtl/sram_req_adapter.sv
// sram_req_adapter: valid/ready request front-end driving a 1-cycle-latency single-port SRAM
module sram_req_adapter
  import sram_adapter_pkg::*;
#(
  parameter int NUM_WORD = SRAM_NUM_WORD,
  parameter int NUM_BIT = SRAM_NUM_BIT,
  parameter int RSP_DEPTH = 2,
  localparam int ADDR_W = $clog2(NUM_WORD)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               scan_en_i,
  input  logic               req_valid_i,
  output logic               req_ready_o,
  input  logic               req_we_i,
  input  logic [ADDR_W-1:0]  req_addr_i,
  input  logic [NUM_BIT-1:0] req_wdata_i,
  output logic               rsp_valid_o,
  input  logic               rsp_ready_i,
  output logic [NUM_BIT-1:0] rsp_rdata_o,
  output logic               sram_ceb_o,
  output logic               sram_web_o,
  output logic [ADDR_W-1:0]  sram_a_o,
  output logic [NUM_BIT-1:0] sram_d_o,
  input  logic [NUM_BIT-1:0] sram_q_i
);
  localparam int CW = $clog2(RSP_DEPTH + 1);
  logic rd_inflight_q, fire, pop, credit_ok, fifo_full, fifo_empty;
  logic [CW-1:0] fifo_count;
  logic [CW:0] occupancy;
  // a read may issue only if its response is guaranteed a FIFO slot at capture time
  assign pop = rsp_valid_o & rsp_ready_i;
  assign occupancy = (CW+1)'(fifo_count) + (CW+1)'(rd_inflight_q) - (CW+1)'(pop);
  assign credit_ok = occupancy < (CW+1)'(RSP_DEPTH);
  assign req_ready_o = ~rst_i & ~scan_en_i & (req_we_i | credit_ok);
  assign fire = req_valid_i & req_ready_o;
  assign sram_ceb_o = ~fire;
  assign sram_web_o = ~(fire & req_we_i);
  assign sram_a_o = req_addr_i;
  assign sram_d_o = req_wdata_i;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) rd_inflight_q <= 1'b0;
    else rd_inflight_q <= fire & ~req_we_i;
  end
  sram_rsp_fifo #(.DEPTH(RSP_DEPTH), .WIDTH(NUM_BIT)) u_fifo (
    .clk(clk_i),
    .rst(rst_i),
    .push(rd_inflight_q),
    .wdata(sram_q_i),
    .pop(pop),
    .rdata(rsp_rdata_o),
    .count(fifo_count),
    .full(fifo_full),
    .empty(fifo_empty)
  );
  assign rsp_valid_o = ~fifo_empty;
  a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i) !(rd_inflight_q && fifo_full));
endmodule

// File: tb/tb_sram_req_adapter.sv
// tb_sram_req_adapter: scoreboard bench with SRAM macro model and reference memory
module tb_sram_req_adapter;
  logic clk = 0, rst = 1, scan_en = 0, req_valid = 0, req_we = 0, rsp_ready = 0;
  logic [10:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic req_ready, rsp_valid, sram_ceb, sram_web;
  logic [31:0] rsp_rdata, sram_d, sram_q;
  logic [10:0] sram_a;
  logic [31:0] sram_mem [2048];
  bit [31:0] ref_mem [2048];
  typedef struct {logic [31:0] d; int t;} exp_t;
  exp_t exp_q[$];
  int cyc = 0, total = 0, passed = 0;

  sram_req_adapter dut (
    .clk_i(clk), .rst_i(rst), .scan_en_i(scan_en),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata),
    .sram_ceb_o(sram_ceb), .sram_web_o(sram_web), .sram_a_o(sram_a),
    .sram_d_o(sram_d), .sram_q_i(sram_q)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // behavioural macro: 1-cycle read latency, Q holds when not enabled
  initial begin
    for (int i = 0; i < 2048; i++) sram_mem[i] = '0;
    sram_q = '0;
  end
  always @(posedge clk)
    if (!sram_ceb) begin
      if (!sram_web) sram_mem[sram_a] <= sram_d;
      else sram_q <= sram_mem[sram_a];
    end

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act === want) passed++;
    else $display("FAIL %s @cyc %0d: got %h want %h", n, cyc, act, want);
  endtask

  // monitor: response scoreboard plus per-cycle request-side expectations
  always @(negedge clk) begin
    if (rst) begin
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_ceb", sram_ceb, 1);
      chk("rst_ready", req_ready, 0);
    end else begin
      int outstanding;
      bit pop, due, exp_ready;
      outstanding = exp_q.size();
      due = outstanding > 0 && cyc >= exp_q[0].t + 2;
      chk("rsp_valid", rsp_valid, due);
      pop = rsp_valid && rsp_ready;
      if (rsp_valid && outstanding > 0) begin
        chk("rsp_rdata", rsp_rdata, exp_q[0].d);
        if (rsp_ready) void'(exp_q.pop_front());
      end
      exp_ready = !scan_en && (req_we || (outstanding - int'(pop)) < 2);
      chk("req_ready", req_ready, exp_ready);
      chk("sram_ceb", sram_ceb, !(req_valid && exp_ready));
      chk("sram_web", sram_web, !(req_valid && exp_ready && req_we));
      if (req_valid && req_ready) begin
        chk("sram_a", {21'b0, sram_a}, {21'b0, req_addr});
        if (req_we) begin
          chk("sram_d", sram_d, req_wdata);
          ref_mem[req_addr] = req_wdata;
        end else exp_q.push_back('{d: ref_mem[req_addr], t: cyc});
      end
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input bit we, input logic [10:0] a, input logic [31:0] d);
    req_valid = 1; req_we = we; req_addr = a; req_wdata = d;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (req_ready) begin
        step();
        req_valid = 0;
        return;
      end
    end
    chk("send_timeout", 0, 1);
    req_valid = 0;
  endtask

  task automatic drain();
    rsp_ready = 1;
    for (int k = 0; k < 50 && exp_q.size() > 0; k++) step();
    chk("drained", exp_q.size(), 0);
  endtask

  initial begin
    step(2);
    rst = 0;
    #1;
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_ceb", sram_ceb, 1);
    chk("reset_web", sram_web, 1);
    step();
    // write then read back, no back-pressure
    rsp_ready = 1;
    send(1, 11'h005, 32'hDEADBEEF);
    send(0, 11'h005, 0);
    step(3);
    chk("deadbeef_ref", ref_mem[5], 32'hDEADBEEF);
    // 16 back-to-back reads
    for (int i = 0; i < 16; i++) send(0, 11'(i), 0);
    drain();
    // read path stalled: only two reads accepted, writes still flow
    rsp_ready = 0;
    send(0, 11'h010, 0);
    send(0, 11'h011, 0);
    req_valid = 1; req_we = 0; req_addr = 11'h012;
    @(negedge clk);
    chk("stall_ready", req_ready, 0);
    step(3);
    send(1, 11'h7FF, 32'h1234_5678);
    rsp_ready = 1;
    send(0, 11'h012, 0);
    send(0, 11'h7FF, 0);
    drain();
    // scan enable blocks issue but the read in flight still returns
    send(0, 11'h005, 0);
    scan_en = 1; req_valid = 1; req_we = 0; req_addr = 11'h006;
    @(negedge clk);
    chk("scan_ready", req_ready, 0);
    chk("scan_ceb", sram_ceb, 1);
    step(3);
    scan_en = 0; req_valid = 0;
    drain();
    // reset with one FIFO entry and one read in flight
    rsp_ready = 0;
    send(0, 11'h001, 0);
    send(0, 11'h002, 0);
    rst = 1; req_valid = 1; req_we = 0; req_addr = 11'h003;
    exp_q.delete();
    #1;
    chk("midrst_rsp_valid", rsp_valid, 0);
    chk("midrst_ceb", sram_ceb, 1);
    step();
    rst = 0; req_valid = 0; rsp_ready = 1;
    step(6);
    // randomized traffic across the full address range
    for (int i = 0; i < 1500; i++) begin
      req_valid = 1'($urandom_range(0, 3) != 0);
      req_we = 1'($urandom_range(0, 2) == 0);
      req_addr = (i < 300) ? 11'($urandom_range(0, 15)) : 11'($urandom);
      req_wdata = $urandom;
      rsp_ready = 1'($urandom_range(0, 2) != 0);
      scan_en = 1'($urandom_range(0, 15) == 0);
      step();
    end
    req_valid = 0; scan_en = 0;
    drain();
    step(3);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
